ft600_rx_block_assembler: RTL

FT600_RX_BLOCK_ASSEMBLER -- requirements
Module: ft600_rx_block_assembler

---
 rtl/ft600_pkg.sv | 45 ++++
 rtl/ft600_rx_block_assembler.sv | 113 +++++++++++
 2 files changed

// File: rtl/ft600_pkg.sv
// Shared constants, state type and byte-lane helper for the FT600 receive block assembler.
package ft600_pkg;

  localparam int BLOCK_BYTES_DEF = 16;
  localparam int BYTE_W          = 8;
  localparam int WORD_W          = 16;
  localparam int BE_W            = 2;

  typedef enum logic {
    FILL       = 1'b0,
    FLUSH_PEND = 1'b1
  } state_t;

  // Enabled bytes of one FT600 word, packed towards b0 in lane order.
  typedef struct packed {
    logic [1:0]        cnt;
    logic [BYTE_W-1:0] b0;
    logic [BYTE_W-1:0] b1;
  } lanes_t;

  // Turn a word plus byte enables into a byte count and the bytes in arrival order.
  function automatic lanes_t compact_lanes(input logic [WORD_W-1:0] data,
                                           input logic [BE_W-1:0]   be);
    lanes_t r;
    r = '0;
    case (be)
      2'b01: begin
        r.cnt = 2'd1;
        r.b0  = data[7:0];
      end
      2'b10: begin
        r.cnt = 2'd1;
        r.b0  = data[15:8];
      end
      2'b11: begin
        r.cnt = 2'd2;
        r.b0  = data[7:0];
        r.b1  = data[15:8];
      end
      default: r.cnt = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ft600_rx_block_assembler.sv
// Packs FT600 16-bit receive words (with byte enables) into fixed-size blocks.
// A full block moves to the output register on the same edge the accumulator
// completes; a flush emits the partial block, zero-padded, once the output frees.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
// once a producer raises valid it holds data stable until that edge, and ready may
// depend on state but never on the partner's valid.
module ft600_rx_block_assembler
  import ft600_pkg::*;
#(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
  localparam int CW = $clog2(BLOCK_BYTES) + 1
) (
  input  logic                          ftdi_clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_W-1:0]             in_data,
  input  logic [BE_W-1:0]               in_be,
  input  logic                          flush,
  output logic                          blk_valid,
  input  logic                          blk_ready,
  output logic [BYTE_W*BLOCK_BYTES-1:0] blk_data,
  output logic [CW-1:0]                 blk_count,
  output state_t                        dbg_state,
  output logic [CW-1:0]                 dbg_acc_count
);

  state_t                        state_q, state_d;
  logic [BYTE_W*BLOCK_BYTES-1:0] acc_q, merged, acc_after;
  logic [CW-1:0]                 acc_count_q, acc_count_after, add_n, sum;
  lanes_t                        lanes;
  logic                          take, complete, out_free, load_partial;

  assign dbg_state     = state_q;
  assign dbg_acc_count = acc_count_q;

  // State register.
  always_ff @(posedge ftdi_clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next state: a flush only arms when bytes remain after this cycle's word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:       if (flush && (acc_count_after != '0)) state_d = FLUSH_PEND;
      FLUSH_PEND: if (out_free) state_d = FILL;
      default:    state_d = FILL;
    endcase
  end

  // FSM outputs: input back-pressure and the partial-block load strobe.
  always_comb begin
    out_free     = !blk_valid || blk_ready;
    in_ready     = !rst && (state_q == FILL) &&
                   !(!out_free && (acc_count_q >= CW'(BLOCK_BYTES - 2)));
    take         = in_valid && in_ready;
    load_partial = (state_q == FLUSH_PEND) && out_free;
  end

  // Merge the accepted bytes at the fill point and split off any overflow byte.
  always_comb begin
    lanes  = compact_lanes(in_data, in_be);
    add_n  = take ? CW'(lanes.cnt) : '0;
    sum    = acc_count_q + add_n;
    merged = acc_q;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (take && (lanes.cnt != 2'd0) && (CW'(k) == acc_count_q))
        merged[BYTE_W*k +: BYTE_W] = lanes.b0;
      if (take && (lanes.cnt == 2'd2) && (CW'(k) == acc_count_q + CW'(1)))
        merged[BYTE_W*k +: BYTE_W] = lanes.b1;
    end
    complete = (sum >= CW'(BLOCK_BYTES));
    if (complete) begin
      acc_count_after = sum - CW'(BLOCK_BYTES);
      acc_after       = '0;
      if (sum > CW'(BLOCK_BYTES)) acc_after[BYTE_W-1:0] = lanes.b1;
    end else begin
      acc_count_after = sum;
      acc_after       = merged;
    end
  end

  // Accumulator and output register; bytes past acc_count are kept zero.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      acc_q       <= '0;
      acc_count_q <= '0;
      blk_valid   <= 1'b0;
      blk_data    <= '0;
      blk_count   <= '0;
    end else if (load_partial) begin
      blk_valid   <= 1'b1;
      blk_data    <= acc_q;
      blk_count   <= acc_count_q;
      acc_q       <= '0;
      acc_count_q <= '0;
    end else begin
      acc_q       <= acc_after;
      acc_count_q <= acc_count_after;
      if (complete) begin
        blk_valid <= 1'b1;
        blk_data  <= merged;
        blk_count <= CW'(BLOCK_BYTES);
      end else if (blk_ready) begin
        blk_valid <= 1'b0;
      end
    end
  end

endmodule
